alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one registered ALU.
// It screens out faulting ops and holds each response until the consumer takes it.
module alu_arbiter #(
  localparam int unsigned DW  = 32,
  localparam int unsigned OPW = 4,
  localparam int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_zero,
  output logic           rsp_err,
  input  logic           rsp_ready,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_status,
  output logic [CW-1:0]  ops_done
);

  localparam logic [OPW-1:0] OP_DIV  = OPW'(4);
  localparam logic [OPW-1:0] OP_LAST = OPW'(8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [DW-1:0]  alu_in1_q, alu_in1_d;
  logic [DW-1:0]  alu_in2_q, alu_in2_d;
  logic           rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_err_q, rsp_err_d;
  logic [CW-1:0]  ops_done_q, ops_done_d;

  logic           gnt_any;
  logic           gnt_id;
  logic           gnt_fault;
  logic [OPW-1:0] gnt_op;
  logic [DW-1:0]  gnt_a;
  logic [DW-1:0]  gnt_b;

  // Candidate grant: prio breaks ties, a lone requester always wins
  always_comb begin
    gnt_any   = req0_valid | req1_valid;
    gnt_id    = (req0_valid & req1_valid) ? prio_q : req1_valid;
    gnt_op    = gnt_id ? req1_op : req0_op;
    gnt_a     = gnt_id ? req1_a  : req0_a;
    gnt_b     = gnt_id ? req1_b  : req0_b;
    gnt_fault = (gnt_op > OP_LAST) || ((gnt_op == OP_DIV) && (gnt_b == '0));
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    alu_op_d   = alu_op_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    ops_done_d = ops_done_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_any && !rst) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          prio_d     = ~gnt_id;
          rsp_id_d   = gnt_id;
          if (gnt_fault) begin
            // Faults bypass the ALU and answer straight away
            rsp_data_d = '0;
            rsp_zero_d = 1'b1;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            alu_op_d  = gnt_op;
            alu_in1_d = gnt_a;
            alu_in2_d = gnt_b;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        rsp_data_d = alu_out;
        rsp_zero_d = alu_status;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        rsp_valid = ~rst;
        if (rsp_ready) begin
          ops_done_d = ops_done_q + CW'(1);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      alu_op_q   <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      alu_op_q   <= alu_op_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_in1  = alu_in1_q;
  assign alu_in2  = alu_in2_q;
  assign rsp_id   = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU with one cycle of register latency stands in for the shared unit.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        alu_status;
  logic [15:0] ops_done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_status(alu_status),
    .ops_done(ops_done)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a * b;
      4'd4: return (b == 32'd0) ? 32'd0 : a / b;
      4'd5: return ~a;
      4'd6: return a - b;
      4'd7: return a >> b[4:0];
      4'd8: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Shared ALU: result and zero flag registered one clock after its inputs
  always @(posedge clk) begin
    alu_out    <= alu_f(alu_op, alu_in1, alu_in2);
    alu_status <= (alu_f(alu_op, alu_in1, alu_in2) == 32'd0);
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd2; req1_valid = 1'b1; req1_op = 4'd1;
    #1;
    chk_cnt++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000)
      $display("FAIL reset_hs: got %b want 000", {req0_ready, req1_ready, rsp_valid});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({rsp_id, rsp_err, rsp_zero, rsp_data, alu_op, alu_in1, alu_in2, ops_done} !== 119'd0)
      $display("FAIL reset_regs: got id=%b err=%b zero=%b data=%h op=%h in1=%h in2=%h done=%h want all 0",
               rsp_id, rsp_err, rsp_zero, rsp_data, alu_op, alu_in1, alu_in2, ops_done);
    else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_grant: got %b want 10", {req0_ready, req1_ready});
    else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0; #1;
    chk_cnt++;
    if ({rsp_valid, alu_op, alu_in1, alu_in2} !== {1'b0, 4'd2, 32'd5, 32'd7})
      $display("FAIL add_issue: got v=%b op=%h in1=%h in2=%h want v=0 op=2 in1=5 in2=7", rsp_valid, alu_op, alu_in1, alu_in2);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) $display("FAIL add_wait: got %b want 000", {rsp_valid, req0_ready, req1_ready});
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, ops_done} !== {4'b1000, 32'd12, 16'd0})
      $display("FAIL add_rsp: got v=%b id=%b err=%b z=%b data=%h done=%h want 1 0 0 0 0000000c 0000",
               rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, ops_done);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, ops_done} !== {1'b0, 16'd1}) $display("FAIL add_done: got v=%b done=%h want v=0 done=0001", rsp_valid, ops_done);
    else pass_cnt++;
  endtask

  // Both requesters hold valid: grants every 4 cycles, alternating 0,1,0,1
  task automatic test_contention();
    logic [1:0] exp_rdy;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd6; req0_a = 32'd9; req0_b = 32'd9;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd0; req1_b = 32'd0;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp_rdy = (c % 4 != 0) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b10 : 2'b01);
      chk_cnt++;
      if ({req0_ready, req1_ready} !== exp_rdy) $display("FAIL cont_grant c=%0d: got %b want %b", c, {req0_ready, req1_ready}, exp_rdy);
      else pass_cnt++;
      if (c % 4 == 3) begin
        chk_cnt++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data} !== {1'b1, 1'((c / 4) % 2), 2'b01, 32'd0})
          $display("FAIL cont_rsp c=%0d: got v=%b id=%b err=%b z=%b data=%h want v=1 id=%0d err=0 z=1 data=0",
                   c, rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, (c / 4) % 2);
        else pass_cnt++;
      end
      if (c == 15) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk);
    end
    #1;
    chk_cnt++;
    if ({rsp_valid, ops_done} !== {1'b0, 16'd4}) $display("FAIL cont_done: got v=%b done=%h want v=0 done=0004", rsp_valid, ops_done);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd3; req0_b = 32'd4;
    #1;
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL bp_grant: got %b want 10", {req0_ready, req1_ready});
    else pass_cnt++;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd1; req1_b = 32'd1;
    @(negedge clk);
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) rsp_ready = 1'b1;
      #1;
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, req0_ready, req1_ready, ops_done} !== {4'b1000, 32'd12, 2'b00, 16'd4})
        $display("FAIL bp_hold T+%0d: got v=%b id=%b err=%b z=%b data=%h rdy=%b%b done=%h want 1 0 0 0 0000000c 00 0004",
                 c, rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, req0_ready, req1_ready, ops_done);
      else pass_cnt++;
    end
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, req0_ready, req1_ready, ops_done} !== {3'b001, 16'd5})
      $display("FAIL bp_next_grant: got v=%b rdy=%b%b done=%h want v=0 rdy=01 done=0005", rsp_valid, req0_ready, req1_ready, ops_done);
    else pass_cnt++;
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data} !== {4'b1100, 32'd2})
      $display("FAIL bp_add_rsp: got v=%b id=%b err=%b z=%b data=%h want 1 1 0 0 00000002", rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (ops_done !== 16'd6) $display("FAIL bp_done: got %h want 0006", ops_done);
    else pass_cnt++;
  endtask

  // Faults answer one cycle after acceptance and leave the ALU drive alone
  task automatic test_faults();
    rsp_ready = 1'b1;
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd10; req1_b = 32'd0;
    #1;
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL div0_grant: got %b want 01", {req0_ready, req1_ready});
    else pass_cnt++;
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd12; req0_a = 32'd3; req0_b = 32'd4;
    #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, req0_ready, req1_ready} !== {4'b1111, 32'd0, 2'b00})
      $display("FAIL div0_rsp: got v=%b id=%b err=%b z=%b data=%h rdy=%b%b want 1 1 1 1 00000000 00",
               rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, req0_ready, req1_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({alu_op, alu_in1, alu_in2} !== {4'd2, 32'd1, 32'd1})
      $display("FAIL div0_alu_hold: got op=%h in1=%h in2=%h want 2 1 1", alu_op, alu_in1, alu_in2);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, req0_ready, req1_ready, ops_done} !== {3'b010, 16'd7})
      $display("FAIL ill_grant: got v=%b rdy=%b%b done=%h want v=0 rdy=10 done=0007", rsp_valid, req0_ready, req1_ready, ops_done);
    else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0; #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, alu_op, alu_in1, alu_in2} !== {4'b1011, 32'd0, 4'd2, 32'd1, 32'd1})
      $display("FAIL ill_rsp: got v=%b id=%b err=%b z=%b data=%h op=%h in1=%h in2=%h want 1 0 1 1 0 2 1 1",
               rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, alu_op, alu_in1, alu_in2);
    else pass_cnt++;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd4; req0_a = 32'd10; req0_b = 32'd2;
    #1;
    chk_cnt++;
    if ({rsp_valid, req0_ready, ops_done} !== {2'b01, 16'd8})
      $display("FAIL div_grant: got v=%b rdy0=%b done=%h want v=0 rdy0=1 done=0008", rsp_valid, req0_ready, ops_done);
    else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data} !== {4'b1000, 32'd5})
      $display("FAIL div_rsp: got v=%b id=%b err=%b z=%b data=%h want 1 0 0 0 00000005", rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk_cnt++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) $display("FAIL rstw_hs: got %b want 000", {rsp_valid, req0_ready, req1_ready});
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd6; req1_a = 32'd5; req1_b = 32'd7;
    #1;
    chk_cnt++;
    if ({rsp_valid, ops_done, req0_ready, req1_ready} !== {1'b0, 16'd0, 2'b01})
      $display("FAIL rstw_after: got v=%b done=%h rdy=%b%b want v=0 done=0000 rdy=01", rsp_valid, ops_done, req0_ready, req1_ready);
    else pass_cnt++;
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data} !== {4'b1100, 32'hFFFF_FFFE})
      $display("FAIL rstw_sub: got v=%b id=%b err=%b z=%b data=%h want 1 1 0 0 fffffffe", rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data);
    else pass_cnt++;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'hF0; req0_b = 32'h3C;
    req1_valid = 1'b1; req1_op = 4'd8; req1_a = 32'd1; req1_b = 32'd4;
    #1;
    chk_cnt++;
    if ({req0_ready, req1_ready, ops_done} !== {2'b10, 16'd1})
      $display("FAIL rstw_both: got rdy=%b%b done=%h want rdy=10 done=0001", req0_ready, req1_ready, ops_done);
    else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data} !== {4'b1000, 32'h30})
      $display("FAIL rstw_and: got v=%b id=%b err=%b z=%b data=%h want 1 0 0 0 00000030", rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    force dut.ops_done_q = 16'hFFFF;
    req0_valid = 1'b1; req0_op = 4'd9; req0_a = 32'd0; req0_b = 32'd0;
    #1;
    chk_cnt++;
    if ({req0_ready, ops_done} !== {1'b1, 16'hFFFF}) $display("FAIL wrap_pre: got rdy0=%b done=%h want rdy0=1 done=ffff", req0_ready, ops_done);
    else pass_cnt++;
    @(negedge clk);
    release dut.ops_done_q;
    req0_valid = 1'b0;
    #1;
    chk_cnt++;
    if ({rsp_valid, rsp_err, ops_done} !== {2'b11, 16'hFFFF}) $display("FAIL wrap_rsp: got v=%b err=%b done=%h want 1 1 ffff", rsp_valid, rsp_err, ops_done);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (ops_done !== 16'h0000) $display("FAIL wrap_done: got %h want 0000", ops_done);
    else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_faults();
    test_reset_in_wait();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
